// File: rtl/rst_seq_ctrl.sv
// Reset and clock-enable sequencer for the MCS8 pipeline: synchronizes reset
// release, holds all stages in reset, releases them in order, then paces CE_O.
module rst_seq_ctrl #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGES      = 3,
  parameter int STAGE_GAP   = 4,
  parameter int CE_DIV      = 2
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              SOFT_RST_I,
  output logic [STAGES-1:0] nRST_O,
  output logic              CE_O,
  output logic              READY_O,
  output logic [1:0]        STATE_O
);

  localparam int CNT_MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_MAX    = (CNT_MAX_HG > CE_DIV) ? CNT_MAX_HG : CE_DIV;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W      = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0]  CE_LAST   = CNT_W'(CE_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STAGES - 1);
  localparam logic [STAGES-1:0] ONE_HOT0  = STAGES'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [STAGES-1:0] r_nrst;
  logic              r_ce;
  logic              r_ready;

  // Both flops set asynchronously; release ripples through on clock edges.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= 1'b0;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_nrst  <= '0;
      r_ce    <= 1'b0;
      r_ready <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
      r_idx <= '0;
      if (!r_sync2) begin
        r_state <= S_HOLD;
      end
    end else if (SOFT_RST_I) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_nrst  <= '0;
      r_ce    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt  <= '0;
            r_nrst <= ONE_HOT0;
            if (STAGES == 1) begin
              r_state <= S_RUN;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_RELEASE;
              r_idx   <= IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt  <= '0;
            r_nrst <= r_nrst | (ONE_HOT0 << r_idx);
            if (r_idx == IDX_LAST) begin
              r_state <= S_RUN;
              r_ready <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // Divider was cleared on entry, so the first pulse lands CE_DIV edges later.
          if (r_cnt == CE_LAST) begin
            r_cnt <= '0;
            r_ce  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_ce  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign nRST_O  = r_nrst;
  assign CE_O    = r_ce;
  assign READY_O = r_ready;
  assign STATE_O = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a default-parameter instance and a
// minimal one (1 stage, CE_DIV=1, HOLD_CYCLES=1), checked edge by edge.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_a, soft_a, rst_b, soft_b;
  logic [2:0] nrst_a;
  logic [0:0] nrst_b;
  logic       ce_a, ce_b, ready_a, ready_b;
  logic [1:0] state_a, state_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  rst_seq_ctrl u_dut_a (
    .CLK_I(clk), .RST_I(rst_a), .SOFT_RST_I(soft_a),
    .nRST_O(nrst_a), .CE_O(ce_a), .READY_O(ready_a), .STATE_O(state_a)
  );

  rst_seq_ctrl #(.HOLD_CYCLES(1), .STAGES(1), .STAGE_GAP(4), .CE_DIV(1)) u_dut_b (
    .CLK_I(clk), .RST_I(rst_b), .SOFT_RST_I(soft_b),
    .nRST_O(nrst_b), .CE_O(ce_b), .READY_O(ready_b), .STATE_O(state_b)
  );

  function automatic logic [11:0] obs_a();
    return {5'b0, nrst_a, ready_a, state_a, ce_a};
  endfunction

  function automatic logic [11:0] obs_b();
    return {7'b0, nrst_b, ready_b, state_b, ce_b};
  endfunction

  // Expected {nRST(8), READY, STATE, CE} m edges after HOLD entry (m<0: IDLE).
  function automatic logic [11:0] model(int m, int h, int g, int s, int c);
    logic [7:0] nr;
    logic       ce;
    int         r, runm, rel;
    if (m < 0) return 12'h000;
    if (m < h) return {8'h00, 1'b0, 2'd1, 1'b0};
    r = m - h;
    if (r >= (s - 1) * g) begin
      runm = r - (s - 1) * g;
      nr   = 8'((1 << s) - 1);
      ce   = (runm >= c) && ((runm % c) == 0);
      return {nr, 1'b1, 2'd3, ce};
    end
    rel = r / g + 1;
    nr  = 8'((1 << rel) - 1);
    return {nr, 1'b0, 2'd2, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges first..last counted from E1; base is the edge that enters HOLD.
  task automatic run_a(input int first, input int last, input int base);
    logic [11:0] exp;
    for (int e = first; e <= last; e++) begin
      sb.push_back(model(e - base, 16, 4, 3, 2));
      tick();
      exp = sb.pop_front();
      chk($sformatf("A_E%0d", e), {20'b0, obs_a()}, {20'b0, exp});
    end
  endtask

  task automatic run_b(input int first, input int last, input int base);
    logic [11:0] exp;
    for (int e = first; e <= last; e++) begin
      sb.push_back(model(e - base, 1, 4, 1, 1));
      tick();
      exp = sb.pop_front();
      chk($sformatf("B_E%0d", e), {20'b0, obs_b()}, {20'b0, exp});
    end
  endtask

  initial begin
    rst_a  = 1'b1;
    soft_a = 1'b0;
    rst_b  = 1'b1;
    soft_b = 1'b0;
    repeat (9) tick();
    chk("A_reset_state", {20'b0, obs_a()}, 32'h0);
    chk("B_reset_state", {20'b0, obs_b()}, 32'h0);
    #14;
    rst_a = 1'b0;

    // Full sequence, then a one-cycle soft reset at E40 in RUN.
    run_a(1, 39, 3);
    soft_a = 1'b1;
    run_a(40, 40, 40);
    soft_a = 1'b0;
    run_a(41, 70, 40);

    // Reset reasserted between edges in the middle of RELEASE.
    rst_a = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
    run_a(1, 21, 3);
    #2;
    rst_a = 1'b1;
    #1;
    chk("A_async_rst_mid_release", {20'b0, obs_a()}, 32'h0);
    tick();
    tick();
    chk("A_idle_while_rst", {20'b0, obs_a()}, 32'h0);
    rst_a = 1'b0;
    run_a(1, 30, 3);

    // Soft reset ignored in IDLE, then held 5 cycles in HOLD.
    rst_a = 1'b1;
    tick();
    tick();
    soft_a = 1'b1;
    rst_a  = 1'b0;
    run_a(1, 2, 3);
    soft_a = 1'b0;
    run_a(3, 9, 3);
    soft_a = 1'b1;
    for (int e = 10; e <= 14; e++) run_a(e, e, e);
    soft_a = 1'b0;
    run_a(15, 35, 14);

    // Both resets high: hard reset wins and holds IDLE.
    rst_a  = 1'b1;
    soft_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("A_both_high_%0d", i), {20'b0, obs_a()}, 32'h0);
    end
    soft_a = 1'b0;
    rst_a  = 1'b0;
    run_a(1, 20, 3);

    // Sub-cycle glitch on RST_I restarts the whole sequence.
    #2;
    rst_a = 1'b1;
    #1;
    chk("A_glitch_async", {20'b0, obs_a()}, 32'h0);
    #1;
    rst_a = 1'b0;
    run_a(1, 32, 3);

    // Minimal configuration: release and READY at E4, CE continuous from E5.
    rst_b = 1'b0;
    run_b(1, 12, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset and clock-enable sequencer for the MCS8 pipeline. It takes the board/bench clock and an asynchronous active-high reset and synchronizes reset release. It holds every pipeline stage in reset for a programmable period, then releases the stages' active-low resets one at a time in fixed order. Once all stages are out of reset it generates the periodic clock-enable that paces the pipeline, and it accepts a synchronous soft-reset request that re-runs the sequence.

## Interface
Parameters:
- HOLD_CYCLES, 16, cycles spent in HOLD before the first stage release; legal range ≥1.
- STAGES, 3, number of stage reset outputs; legal range 1..8.
- STAGE_GAP, 4, cycles between consecutive stage releases; legal range ≥1.
- CE_DIV, 2, clock-enable period in cycles; legal range ≥1.

Ports:
- CLK_I  input  1  sole clock; all state changes on rising edge.
- RST_I  input  1  reset, asynchronous, active-high.
- SOFT_RST_I  input  1  synchronous soft-reset request, sampled each edge.
- nRST_O  output  STAGES  per-stage reset, active-low; bit k released k-th.
- CE_O  output  1  pipeline clock-enable; registered, one-cycle pulses.
- READY_O  output  1  high while all stages are released (state RUN).
- STATE_O  output  2  FSM state: 0 IDLE, 1 HOLD, 2 RELEASE, 3 RUN.

## Operation
- Reset sync: two flops, both asynchronously set by RST_I and cleared in sequence by CLK_I after RST_I falls. The FSM sees only the synchronized reset.
- RST_I high, anywhere and mid-anything, immediately forces:
  - state IDLE, synchronizer set, counters 0
  - nRST_O all 0, CE_O 0, READY_O 0, STATE_O 0
- IDLE: stay while the synchronized reset is high. Go to HOLD at the first edge that samples it low.
- HOLD: counter counts cycles. Go to RELEASE after exactly HOLD_CYCLES cycles in HOLD. nRST_O stays all 0.
- RELEASE:
  - Entry edge sets nRST_O[0]=1.
  - Each following STAGE_GAP-th edge sets the next bit; released bits stay 1.
  - The edge that releases bit STAGES-1 also moves the state to RUN and sets READY_O=1.
  - If STAGES=1, the entry edge goes straight to RUN.
- RUN:
  - CE divider clears on entry.
  - CE_O=1 for one cycle every CE_DIV cycles; the first pulse starts CE_DIV edges after RUN entry.
  - If CE_DIV=1, CE_O stays high from the edge after RUN entry onward.
- SOFT_RST_I high at an edge in HOLD, RELEASE or RUN:
  - next state HOLD, counters cleared
  - nRST_O all 0, READY_O 0, CE_O 0 on that same edge
  - In HOLD this restarts the full HOLD_CYCLES count.
- SOFT_RST_I is ignored in IDLE.
- Priority: RST_I > SOFT_RST_I > normal sequencing.
- Counter widths are sized from the parameters with $clog2; counters never wrap inside a state.

## Timing
- All outputs are registered; no combinational path from input to output.
- Let E1 be the first rising edge after RST_I falls.
  - E1: sync stage 1 clears.
  - E2: sync stage 2 clears.
  - E3: state goes to HOLD.
  - E(3+HOLD_CYCLES): RELEASE, nRST_O[0]=1.
  - E(3+HOLD_CYCLES+k·STAGE_GAP): nRST_O[k]=1.
  - READY_O rises together with nRST_O[STAGES-1].
- Defaults give:
  - E19: nRST_O=3'b001
  - E23: nRST_O=3'b011
  - E27: nRST_O=3'b111, READY_O=1, RUN
  - CE_O high in the cycles starting at E29, E31, E33, …
- Soft reset at edge Es: HOLD at Es, first release at Es+HOLD_CYCLES.
- RST_I assertion acts asynchronously, with no clock edge needed. A glitch shorter than one cycle still fully restarts the sequence.

## Test plan
- Default parameters, RST_I high 100 ns then low, 10 ns clock: nRST_O goes 000→001→011→111 at E19/E23/E27; READY_O rises at E27; CE_O pulses at E29, E31 and every 2 cycles after.
- RST_I reasserted at E21 (mid-RELEASE, between edges): nRST_O=000, STATE_O=0 and READY_O=0 immediately with no edge. After release the full sequence repeats, with timing counted from the new E1.
- SOFT_RST_I one-cycle pulse at E40 (RUN): at E40 nRST_O=000, CE_O=0, STATE_O=1. nRST_O[0] rises at E56, READY_O at E64.
- SOFT_RST_I held high for 5 cycles from E10 (HOLD): HOLD restarts each edge; first release 16 edges after the last high sample (E30). Asserting SOFT_RST_I in IDLE has no effect.
- STAGES=1, CE_DIV=1, HOLD_CYCLES=1: nRST_O=1 and READY_O=1 at E4, and CE_O is continuously high from E5.
- RST_I and SOFT_RST_I both high: RST_I wins, state IDLE, and the sequence resumes only after RST_I falls.
